// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bundle: in/out handshakes, flush, and EX/WB forward buses.
// No logic, only wiring.
// The master drives in_*, flush, the forward buses and out_ready; the slave (the issue stage) drives in_ready and out_*.
interface alu_issue_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [REG_AW-1:0] in_rs1_idx;
    logic [REG_AW-1:0] in_rs2_idx;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic              in_use_imm;
    logic [REG_AW-1:0] in_rd_idx;
    logic              ex_fwd_valid;
    logic [REG_AW-1:0] ex_fwd_idx;
    logic [XLEN-1:0]   ex_fwd_data;
    logic              wb_fwd_valid;
    logic [REG_AW-1:0] wb_fwd_idx;
    logic [XLEN-1:0]   wb_fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_op;
    logic [XLEN-1:0]   out_rs1;
    logic [XLEN-1:0]   out_rs2;
    logic [REG_AW-1:0] out_rd_idx;

    modport master (
        output flush, in_valid, in_op, in_rs1_idx, in_rs2_idx, in_rs1_val,
               in_rs2_val, in_imm, in_use_imm, in_rd_idx,
               ex_fwd_valid, ex_fwd_idx, ex_fwd_data,
               wb_fwd_valid, wb_fwd_idx, wb_fwd_data, out_ready,
        input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd_idx
    );

    modport slave (
        input  flush, in_valid, in_op, in_rs1_idx, in_rs2_idx, in_rs1_val,
               in_rs2_val, in_imm, in_use_imm, in_rd_idx,
               ex_fwd_valid, ex_fwd_idx, ex_fwd_data,
               wb_fwd_valid, wb_fwd_idx, wb_fwd_data, out_ready,
        output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd_idx
    );
endinterface

// File: rtl/alu_issue.sv
// ALU operand-issue stage: operand-2 select, EX/WB forwarding at capture, and snooping while buffered.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a two-entry skid buffer with a registered in_ready that drops only when both entries are full.
module alu_issue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_issue_if.slave bus
);
    typedef struct packed {
        logic [3:0]        op;
        logic [XLEN-1:0]   v1;
        logic [XLEN-1:0]   v2;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] idx1;
        logic [REG_AW-1:0] idx2;
        logic              trk1;
        logic              trk2;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t r_state;
    state_t w_state_n;
    entry_t r_head;
    entry_t r_skid;
    entry_t w_head_n;
    entry_t w_skid_n;
    entry_t w_new;
    logic   r_in_rdy;
    logic   w_in_xfer;
    logic   w_out_xfer;
    logic   w_out_vld;

    // EX has priority over WB. Tracked sources never have index 0, so x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] idx,
        input logic              trk,
        input logic [XLEN-1:0]   cur,
        input logic              ex_v,
        input logic [REG_AW-1:0] ex_i,
        input logic [XLEN-1:0]   ex_d,
        input logic              wb_v,
        input logic [REG_AW-1:0] wb_i,
        input logic [XLEN-1:0]   wb_d
    );
        logic [XLEN-1:0] res;
        res = cur;
        if (trk && ex_v && (ex_i == idx)) begin
            res = ex_d;
        end else if (trk && wb_v && (wb_i == idx)) begin
            res = wb_d;
        end
        return res;
    endfunction

    assign w_out_vld  = (r_state != S_EMPTY);
    assign w_in_xfer  = bus.in_valid && r_in_rdy;
    assign w_out_xfer = w_out_vld && bus.out_ready;

    // Build the incoming entry: select operand 2 and resolve hazards against this cycle's forwards.
    always_comb begin
        w_new      = '0;
        w_new.op   = bus.in_op;
        w_new.rd   = bus.in_rd_idx;
        w_new.idx1 = bus.in_rs1_idx;
        w_new.idx2 = bus.in_rs2_idx;
        w_new.trk1 = (bus.in_rs1_idx != '0);
        w_new.trk2 = (bus.in_rs2_idx != '0) && !bus.in_use_imm;
        w_new.v1   = fwd_sel(bus.in_rs1_idx, w_new.trk1, bus.in_rs1_val,
                             bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                             bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);
        if (bus.in_use_imm) begin
            w_new.v2 = bus.in_imm;
        end else begin
            w_new.v2 = fwd_sel(bus.in_rs2_idx, w_new.trk2, bus.in_rs2_val,
                               bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                               bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);
        end
    end

    // Next state and next entry contents; snoop is applied after any skid-to-head move.
    always_comb begin
        w_state_n = r_state;
        w_head_n  = r_head;
        w_skid_n  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_head_n  = w_new;
                    w_state_n = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_head_n = w_new;
                end else if (w_in_xfer) begin
                    w_skid_n  = w_new;
                    w_state_n = S_TWO;
                end else if (w_out_xfer) begin
                    w_state_n = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_xfer) begin
                    w_head_n  = r_skid;
                    w_state_n = S_ONE;
                end
            end
            default: w_state_n = S_EMPTY;
        endcase

        w_head_n.v1 = fwd_sel(w_head_n.idx1, w_head_n.trk1, w_head_n.v1,
                              bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);
        w_head_n.v2 = fwd_sel(w_head_n.idx2, w_head_n.trk2, w_head_n.v2,
                              bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);
        w_skid_n.v1 = fwd_sel(w_skid_n.idx1, w_skid_n.trk1, w_skid_n.v1,
                              bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);
        w_skid_n.v2 = fwd_sel(w_skid_n.idx2, w_skid_n.trk2, w_skid_n.v2,
                              bus.ex_fwd_valid, bus.ex_fwd_idx, bus.ex_fwd_data,
                              bus.wb_fwd_valid, bus.wb_fwd_idx, bus.wb_fwd_data);

        // A branch redirect empties the stage and drops any same-cycle input.
        if (bus.flush) begin
            w_state_n = S_EMPTY;
        end
    end

    // State and entry registers. in_ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_head   <= '0;
            r_skid   <= '0;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_head   <= w_head_n;
            r_skid   <= w_skid_n;
            r_in_rdy <= (w_state_n != S_TWO);
        end
    end

    assign bus.in_ready   = r_in_rdy;
    assign bus.out_valid  = w_out_vld;
    assign bus.out_op     = r_head.op;
    assign bus.out_rs1    = r_head.v1;
    assign bus.out_rs2    = r_head.v2;
    assign bus.out_rd_idx = r_head.rd;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, operand select, forwarding, backpressure, snoop, flush.
// Inputs change 1 ns after the rising edge, and outputs are checked at that same point.
// Every check is an immediate assertion that counts failures.
module tb_alu_issue;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_issue_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_issue #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] i1, input logic [31:0] v1,
                         input logic [4:0] i2, input logic [31:0] v2, input logic use_imm,
                         input logic [31:0] imm, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_rs1_idx = i1;
        bus.in_rs1_val = v1;
        bus.in_rs2_idx = i2;
        bus.in_rs2_val = v2;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        bus.in_rd_idx  = rd;
    endtask

    task automatic no_fwd();
        bus.ex_fwd_valid = 1'b0;
        bus.ex_fwd_idx   = '0;
        bus.ex_fwd_data  = '0;
        bus.wb_fwd_valid = 1'b0;
        bus.wb_fwd_idx   = '0;
        bus.wb_fwd_data  = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0);
        bus.in_valid = 1'b0;
        no_fwd();

        // Reset
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_rs1", bus.out_rs1, 32'd0);
        chk("rst_out_rs2", bus.out_rs2, 32'd0);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd_idx), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic ADD x1(5), x2(7)
        bus.out_ready = 1'b1;
        drive(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 5'd3);
        step();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_rs1", bus.out_rs1, 32'd5);
        chk("add_rs2", bus.out_rs2, 32'd7);
        chk("add_op", 32'(bus.out_op), 32'(ALU_ADD));
        chk("add_rd", 32'(bus.out_rd_idx), 32'd3);
        step();
        chk("add_drained", 32'(bus.out_valid), 32'd0);

        // Immediate select ignores a WB hit on rs2
        drive(ALU_SUB, 5'd0, 32'h77, 5'd3, 32'h1111, 1'b1, 32'hFFFF_FFF0, 5'd9);
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_idx = 5'd3; bus.wb_fwd_data = 32'd99;
        step();
        bus.in_valid = 1'b0; no_fwd();
        chk("imm_rs2", bus.out_rs2, 32'hFFFF_FFF0);
        chk("imm_rs1_x0", bus.out_rs1, 32'h77);
        chk("imm_op", 32'(bus.out_op), 32'(ALU_SUB));
        step();

        // EX beats WB on the same index
        drive(ALU_AND, 5'd4, 32'd1, 5'd0, 32'd2, 1'b0, 32'd0, 5'd4);
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_idx = 5'd4; bus.ex_fwd_data = 32'h10;
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_idx = 5'd4; bus.wb_fwd_data = 32'h20;
        step();
        bus.in_valid = 1'b0; no_fwd();
        chk("prio_ex_rs1", bus.out_rs1, 32'h10);
        chk("prio_rs2_x0", bus.out_rs2, 32'd2);
        step();

        // x0 never forwarded; WB-only hit on rs2
        drive(ALU_OR, 5'd0, 32'h33, 5'd8, 32'd3, 1'b0, 32'd0, 5'd1);
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_idx = 5'd0; bus.ex_fwd_data = 32'h55;
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_idx = 5'd8; bus.wb_fwd_data = 32'h44;
        step();
        bus.in_valid = 1'b0; no_fwd();
        chk("x0_no_fwd", bus.out_rs1, 32'h33);
        chk("wb_fwd_rs2", bus.out_rs2, 32'h44);
        step();

        // Backpressure: A, B, C back to back with out_ready low
        bus.out_ready = 1'b0;
        drive(ALU_XOR, 5'd0, 32'hA, 5'd0, 32'h0, 1'b0, 32'd0, 5'd10);
        step();
        chk("bp_a_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_rdy_after_a", 32'(bus.in_ready), 32'd1);
        drive(ALU_XOR, 5'd0, 32'hB, 5'd0, 32'h0, 1'b0, 32'd0, 5'd11);
        step();
        chk("bp_rdy_after_b", 32'(bus.in_ready), 32'd0);
        chk("bp_head_a", bus.out_rs1, 32'hA);
        drive(ALU_XOR, 5'd0, 32'hC, 5'd0, 32'h0, 1'b0, 32'd0, 5'd12);
        step();
        chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_a", bus.out_rs1, 32'hA);
        chk("bp_hold_rd", 32'(bus.out_rd_idx), 32'd10);
        bus.out_ready = 1'b1;
        step();
        chk("bp_head_b", bus.out_rs1, 32'hB);
        chk("bp_b_rdy", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_head_c", bus.out_rs1, 32'hC);
        chk("bp_c_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Snoop while stalled
        bus.out_ready = 1'b0;
        drive(ALU_AND, 5'd6, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd6);
        step();
        bus.in_valid = 1'b0;
        chk("snoop_before", bus.out_rs1, 32'd0);
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_idx = 5'd6; bus.ex_fwd_data = 32'hABCD;
        step();
        no_fwd();
        chk("snoop_after", bus.out_rs1, 32'hABCD);
        chk("snoop_valid", 32'(bus.out_valid), 32'd1);

        // Flush from TWO with input valid
        drive(ALU_OR, 5'd0, 32'hD, 5'd0, 32'd0, 1'b0, 32'd0, 5'd13);
        step();
        chk("fl_two_rdy", 32'(bus.in_ready), 32'd0);
        drive(ALU_OR, 5'd0, 32'hE, 5'd0, 32'd0, 1'b0, 32'd0, 5'd14);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_rdy", 32'(bus.in_ready), 32'd1);
        step();
        chk("fl_still_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        drive(ALU_SUB, 5'd0, 32'hF, 5'd0, 32'h1, 1'b0, 32'd0, 5'd15);
        step();
        bus.in_valid = 1'b0;
        chk("fl_new_valid", 32'(bus.out_valid), 32'd1);
        chk("fl_new_rs1", bus.out_rs1, 32'hF);
        chk("fl_new_rd", 32'(bus.out_rd_idx), 32'd15);
        step();
        chk("fl_new_drained", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation
        bus.out_ready = 1'b0;
        drive(ALU_XOR, 5'd0, 32'h5A, 5'd0, 32'h0, 1'b0, 32'd0, 5'd7);
        step();
        bus.in_valid = 1'b0;
        chk("mid_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_op", 32'(bus.out_op), 32'd0);
        chk("mid_rst_rs1", bus.out_rs1, 32'd0);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
